anc_stream_feeder: RTL and testbench
====================================

Name: anc_stream_feeder

Overview:
- Upstream sample source for the ANC core. It buffers per-sample tuples (x, e, a) arriving at audio rate.
- Drives the core's in_valid/controller_ready handshake one sample at a time, supplying the configured step size.
- Waits for the matching out_valid, then forwards the anti-noise result to the DAC-side sink.
- Supervises overflow and core-stall conditions with sticky status flags.

Parameters:
- DEPTH, 8, tuple FIFO entries; must be a power of 2, minimum 2.
- DW, 16, sample width (signed).
- TIMEOUT, 1024, maximum cycles to wait for out_valid after a transfer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- s_valid  in  1  producer strobe; the tuple is valid this cycle. The producer cannot be stalled.
- s_x  in  DW  reference-mic sample.
- s_e  in  DW  error-mic sample.
- s_a  in  DW  desired-output sample.
- mu_cfg  in  DW  LMS step size; sampled at each transfer.
- in_valid  out  1  to core: tuple presented.
- controller_ready  in  1  from core: ready to accept.
- x_in  out  DW  to core.
- e_in  out  DW  to core.
- a_in  out  DW  to core.
- u_in  out  DW  to core.
- out_sample  in  DW  from core: FIR result.
- out_valid  in  1  from core: result strobe.
- y_valid  out  1  one-cycle strobe to sink.
- y_data  out  DW  result to sink.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a tuple was dropped.
- timeout  out  1  sticky: the core failed to respond.
- clr_status  in  1  clears overflow and timeout.

Behaviour:
- Reset (rst_n low at a clk edge) has priority over everything.
  - FIFO pointers and level are set to 0.
  - The FSM goes to IDLE; the timeout counter is set to 0.
  - in_valid, y_valid, overflow and timeout go to 0. x_in, e_in, a_in, u_in and y_data go to 0.
  - Reset mid-transaction discards the FIFO contents and any pending result. A late out_valid after reset is ignored, because the FSM is in IDLE.
- FIFO:
  - Push occurs on s_valid when not full, or when full and a pop happens in the same cycle.
  - If s_valid arrives while full with no pop, the tuple is dropped and overflow is set.
  - Pointers wrap modulo DEPTH. fifo_level is exact, and is unchanged on a simultaneous push and pop.
- FSM states:
  - IDLE:
    - If the FIFO is not empty: pop the head into the x_in/e_in/a_in registers, latch mu_cfg into u_in, assert in_valid, and go to ISSUE.
    - A tuple pushed into an empty FIFO in cycle N therefore gives in_valid high in cycle N+1 (no same-cycle bypass).
  - ISSUE:
    - in_valid and the data stay constant until a cycle where in_valid and controller_ready are both 1. That cycle is the transfer.
    - At the transfer edge, deassert in_valid, clear the timeout counter and go to WAIT_OUT.
    - If controller_ready is already high on entry, the transfer happens in the first ISSUE cycle.
  - WAIT_OUT:
    - The counter increments each cycle.
    - On out_valid: register out_sample into y_data, pulse y_valid in the next cycle, and return to IDLE.
    - If the counter reaches TIMEOUT-1 without out_valid: set timeout, y_data = 0 with a y_valid pulse (preserves sample cadence), and return to IDLE.
    - If out_valid and the timeout occur in the same cycle, out_valid wins.
- out_valid in IDLE or ISSUE is ignored.
- Exactly one tuple is outstanding at the core at a time.
- Back-to-back throughput is one tuple per (transfer + core latency + 1) cycles. After y_valid, IDLE can issue the next tuple in the same cycle.
- clr_status clears both sticky flags. If a set event occurs in the same cycle, set wins.
- No arithmetic on the data: pure pass-through, signed DW bits, no width change.

Decomposition:
- Shared package anc_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT_OUT);
  - a tuple struct {x, e, a} of DW-bit signed fields;
  - the DW default constant.
- The FIFO becomes sub-module anc_sample_fifo: parameterised DEPTH/width, push/pop/full/empty/level, with the overflow drop rule internal.
- The FSM, timeout counter and status logic stay in the top level.

Test Plan:
- Single sample:
  - Stimulus: push x=0x0100, e=0xFF00, a=0x0010 with mu_cfg=0x0040; core model ready; out_sample=0x1234 arrives 5 cycles after the transfer.
  - Required: in_valid 1 cycle after the push carrying exactly those values with u_in=0x0040; y_valid with y_data=0x1234 one cycle after out_valid; fifo_level returns to 0.
- Backpressure:
  - Stimulus: controller_ready held low 20 cycles after in_valid rises.
  - Required: in_valid and x/e/a/u stable for all 20 cycles; exactly one transfer when ready rises; no duplicate issue.
- Overflow:
  - Stimulus: core never ready; push 10 tuples with DEPTH=8.
  - Required: one tuple in ISSUE plus 8 in the FIFO; the 10th is dropped and overflow=1.
  - Follow-up: clr_status clears overflow; draining yields values 1..9 in order.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full; s_valid in the IDLE-pop cycle.
  - Required: no overflow; level stays 8.
- Timeout:
  - Stimulus: TIMEOUT=16; core accepts but never asserts out_valid.
  - Required: y_valid with y_data=0 after 16 WAIT_OUT cycles; timeout=1; the next queued tuple issues.
  - Follow-up: an out_valid arriving later is ignored.
- Reset mid-WAIT_OUT with 3 tuples queued:
  - Required: the next cycle has all outputs at 0 and fifo_level=0; out_valid 2 cycles later yields no y_valid.

Source files
------------

// File: rtl/anc_pkg.sv
// anc_pkg: shared types for the ANC sample feeder.
//   DW_DEFAULT - default signed sample width
//   state_t    - feeder FSM states (IDLE, ISSUE, WAIT_OUT)
//   tuple_t    - one (x, e, a) sample tuple at the default width
package anc_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [DW_DEFAULT-1:0] x;
        logic signed [DW_DEFAULT-1:0] e;
        logic signed [DW_DEFAULT-1:0] a;
    } tuple_t;

endpackage

// File: rtl/anc_sample_fifo.sv
// anc_sample_fifo: tuple FIFO between the audio-rate producer and the feeder FSM.
// The producer cannot be stalled, so a push into a full FIFO is dropped unless
// a pop happens in the same cycle; a drop is reported on 'dropped'.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   push       - producer strobe
//   wdata      - tuple to store
//   pop        - consumer takes the head (ignored when empty)
//   rdata      - head of the FIFO (combinational)
//   empty      - no entries stored
//   level      - exact occupancy, 0..DEPTH
//   dropped    - one-cycle pulse: push refused because the FIFO was full
module anc_sample_fifo
    import anc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 3 * DW_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);

    // A pop in the same cycle frees the slot the push needs, so full only
    // blocks a push when nothing leaves.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && full && !do_pop;

    assign rdata = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/anc_stream_feeder.sv
// anc_stream_feeder: buffers (x, e, a) sample tuples and feeds them to the ANC
// core one at a time, then forwards the core's result to the DAC-side sink.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   s_valid, s_x, s_e, s_a     - producer tuple strobe and samples (never stalled)
//   mu_cfg                     - LMS step size, latched into u_in at each issue
//   in_valid, controller_ready - handshake towards the core
//   x_in, e_in, a_in, u_in     - tuple and step size presented to the core
//   out_sample, out_valid      - result strobe from the core
//   y_valid, y_data            - one-cycle result strobe to the sink
//   fifo_level                 - current FIFO occupancy
//   overflow, timeout          - sticky status flags, cleared by clr_status
module anc_stream_feeder
    import anc_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic signed [DW-1:0]   s_x,
    input  logic signed [DW-1:0]   s_e,
    input  logic signed [DW-1:0]   s_a,
    input  logic signed [DW-1:0]   mu_cfg,
    output logic                   in_valid,
    input  logic                   controller_ready,
    output logic signed [DW-1:0]   x_in,
    output logic signed [DW-1:0]   e_in,
    output logic signed [DW-1:0]   a_in,
    output logic signed [DW-1:0]   u_in,
    input  logic signed [DW-1:0]   out_sample,
    input  logic                   out_valid,
    output logic                   y_valid,
    output logic signed [DW-1:0]   y_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   timeout,
    input  logic                   clr_status
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nx;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nx;
    logic                in_valid_nx;
    logic signed [DW-1:0] x_nx;
    logic signed [DW-1:0] e_nx;
    logic signed [DW-1:0] a_nx;
    logic signed [DW-1:0] u_nx;
    logic                y_valid_nx;
    logic signed [DW-1:0] y_data_nx;
    logic                pop;
    logic                timeout_evt;
    logic                dropped;
    logic                fifo_empty;
    logic [3*DW-1:0]     fifo_rdata;

    anc_sample_fifo #(
        .DEPTH (DEPTH),
        .W     (3 * DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (s_valid),
        .wdata   ({s_x, s_e, s_a}),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .dropped (dropped)
    );

    // Sticky flags: a set event in the same cycle as clr_status wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            in_valid <= 1'b0;
            x_in     <= '0;
            e_in     <= '0;
            a_in     <= '0;
            u_in     <= '0;
            y_valid  <= 1'b0;
            y_data   <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            in_valid <= in_valid_nx;
            x_in     <= x_nx;
            e_in     <= e_nx;
            a_in     <= a_nx;
            u_in     <= u_nx;
            y_valid  <= y_valid_nx;
            y_data   <= y_data_nx;
            overflow <= dropped | (overflow & ~clr_status);
            timeout  <= timeout_evt | (timeout & ~clr_status);
        end
    end

    // Only one tuple is ever outstanding at the core. A timeout still emits a
    // zero-valued y_valid so the sink keeps its sample cadence; a real
    // out_valid in the same cycle as the last count takes precedence.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        in_valid_nx = in_valid;
        x_nx        = x_in;
        e_nx        = e_in;
        a_nx        = a_in;
        u_nx        = u_in;
        y_valid_nx  = 1'b0;
        y_data_nx   = y_data;
        pop         = 1'b0;
        timeout_evt = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    x_nx        = fifo_rdata[3*DW-1:2*DW];
                    e_nx        = fifo_rdata[2*DW-1:DW];
                    a_nx        = fifo_rdata[DW-1:0];
                    u_nx        = mu_cfg;
                    in_valid_nx = 1'b1;
                    state_nx    = ISSUE;
                end
            end
            ISSUE: begin
                if (in_valid && controller_ready) begin
                    in_valid_nx = 1'b0;
                    cnt_nx      = '0;
                    state_nx    = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (out_valid) begin
                    y_data_nx  = out_sample;
                    y_valid_nx = 1'b1;
                    state_nx   = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_evt = 1'b1;
                    y_data_nx   = '0;
                    y_valid_nx  = 1'b1;
                    state_nx    = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_anc_stream_feeder.sv
// tb_anc_stream_feeder: scoreboard bench for anc_stream_feeder.
// Stimulus pushes expected core transfers and sink results into queues; two
// monitors pop and compare whenever the DUT presents a transfer or y_valid.
// A small core model answers each transfer with x + CORE_OFS after a latency.
module tb_anc_stream_feeder;
    import anc_pkg::*;

    localparam int DW      = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam logic [DW-1:0] CORE_OFS = 16'h1134;

    typedef struct packed {
        tuple_t          t;
        logic [DW-1:0]   u;
    } tx_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   s_valid;
    logic [DW-1:0]          s_x, s_e, s_a, mu_cfg;
    logic                   in_valid;
    logic                   controller_ready;
    logic [DW-1:0]          x_in, e_in, a_in, u_in;
    logic [DW-1:0]          out_sample;
    logic                   out_valid;
    logic                   y_valid;
    logic [DW-1:0]          y_data;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic                   timeout;
    logic                   clr_status;

    int vectors = 0;
    int errors  = 0;
    int tx_seen = 0;
    int inject_req = 0;
    bit core_respond = 1'b0;
    int core_latency = 5;

    tx_t           exp_tx[$];
    logic [DW-1:0] exp_y[$];

    always #5 clk = ~clk;

    anc_stream_feeder #(
        .DEPTH   (DEPTH),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_valid          (s_valid),
        .s_x              (s_x),
        .s_e              (s_e),
        .s_a              (s_a),
        .mu_cfg           (mu_cfg),
        .in_valid         (in_valid),
        .controller_ready (controller_ready),
        .x_in             (x_in),
        .e_in             (e_in),
        .a_in             (a_in),
        .u_in             (u_in),
        .out_sample       (out_sample),
        .out_valid        (out_valid),
        .y_valid          (y_valid),
        .y_data           (y_data),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .timeout          (timeout),
        .clr_status       (clr_status)
    );

    task automatic check_output(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [DW-1:0] x, input logic [DW-1:0] e, input logic [DW-1:0] a,
                                  input bit expect_tx, input bit expect_y, input logic [DW-1:0] y);
        tx_t t;
        s_valid = 1'b1;
        s_x = x;
        s_e = e;
        s_a = a;
        if (expect_tx) begin
            t.t.x = x;
            t.t.e = e;
            t.t.a = a;
            t.u   = mu_cfg;
            exp_tx.push_back(t);
        end
        if (expect_y) exp_y.push_back(y);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_in_valid(input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (in_valid === 1'b1) found = 1'b1;
        end
        check_output(name, 16'(found), 16'h1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (exp_tx.size() == 0 && exp_y.size() == 0) done = 1'b1;
        end
        check_output(name, 16'(done), 16'h1);
    endtask

    // Sink-side monitor: every y_valid must match the oldest expected result.
    initial begin : y_monitor
        logic [DW-1:0] want;
        forever begin
            @(negedge clk);
            if (y_valid === 1'b1) begin
                if (exp_y.size() == 0) begin
                    check_output("y_valid_unexpected", 16'(y_valid), 16'h0);
                end else begin
                    want = exp_y.pop_front();
                    check_output("y_data", y_data, want);
                end
            end
        end
    end

    // Core-side monitor: every accepted transfer must match the oldest expected tuple.
    initial begin : tx_monitor
        tx_t want;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && in_valid === 1'b1 && controller_ready === 1'b1) begin
                tx_seen++;
                if (exp_tx.size() == 0) begin
                    check_output("tx_unexpected", 16'(in_valid), 16'h0);
                end else begin
                    want = exp_tx.pop_front();
                    check_output("tx_x", x_in, want.t.x);
                    check_output("tx_e", e_in, want.t.e);
                    check_output("tx_a", a_in, want.t.a);
                    check_output("tx_u", u_in, want.u);
                end
            end
        end
    end

    // Core model: result = x + CORE_OFS, core_latency cycles after the transfer.
    // Also issues stray out_valid pulses on request.
    initial begin : core_model
        logic [DW-1:0] cap;
        int served;
        served = 0;
        out_valid = 1'b0;
        out_sample = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && in_valid === 1'b1 && controller_ready === 1'b1 && core_respond) begin
                cap = x_in;
                repeat (core_latency) @(posedge clk);
                #1;
                out_sample = cap + CORE_OFS;
                out_valid = 1'b1;
                @(posedge clk);
                #1;
                out_valid = 1'b0;
            end else if (served != inject_req) begin
                served++;
                @(posedge clk);
                #1;
                out_sample = 16'h7777;
                out_valid = 1'b1;
                @(posedge clk);
                #1;
                out_valid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit found;
        int stable;
        int lat;
        int bad;
        int tx_before;

        rst_n = 1'b0;
        s_valid = 1'b0;
        s_x = '0;
        s_e = '0;
        s_a = '0;
        mu_cfg = '0;
        controller_ready = 1'b0;
        clr_status = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check_output("rst_in_valid", 16'(in_valid), 16'h0);
        check_output("rst_y_valid", 16'(y_valid), 16'h0);
        check_output("rst_overflow", 16'(overflow), 16'h0);
        check_output("rst_timeout", 16'(timeout), 16'h0);
        check_output("rst_level", 16'(fifo_level), 16'h0);
        check_output("rst_x_in", x_in, 16'h0);
        check_output("rst_y_data", y_data, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single sample: result 0x0100 + 0x1134 = 0x1234, latency 5
        $display("[TB] single sample");
        controller_ready = 1'b1;
        core_respond = 1'b1;
        core_latency = 5;
        mu_cfg = 16'h0040;
        apply_stimulus(16'h0100, 16'hFF00, 16'h0010, 1'b1, 1'b1, 16'h1234);
        @(negedge clk);
        check_output("t1_no_bypass", 16'(in_valid), 16'h0);
        check_output("t1_level_after_push", 16'(fifo_level), 16'h1);
        @(negedge clk);
        check_output("t1_in_valid", 16'(in_valid), 16'h1);
        wait_drain(40, "t1_drain");
        @(negedge clk);
        check_output("t1_level_end", 16'(fifo_level), 16'h0);
        check_output("t1_in_valid_end", 16'(in_valid), 16'h0);
        tick();

        // Backpressure: ready low for 20 cycles after in_valid rises
        $display("[TB] backpressure");
        controller_ready = 1'b0;
        core_latency = 3;
        mu_cfg = 16'h0055;
        tx_before = tx_seen;
        apply_stimulus(16'h0A0A, 16'h0B0B, 16'h0C0C, 1'b1, 1'b1, 16'h1B3E);
        wait_in_valid(10, "t2_issue");
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (in_valid === 1'b1 && x_in === 16'h0A0A && e_in === 16'h0B0B &&
                a_in === 16'h0C0C && u_in === 16'h0055) stable++;
        end
        check_output("t2_stable", 16'(stable), 16'd20);
        tick();
        controller_ready = 1'b1;
        wait_drain(40, "t2_drain");
        repeat (4) tick();
        check_output("t2_single_transfer", 16'(tx_seen - tx_before), 16'd1);

        // Overflow: core never ready, 10 pushes; 1 in ISSUE, 8 queued, 10th dropped
        $display("[TB] overflow");
        controller_ready = 1'b0;
        core_latency = 2;
        mu_cfg = 16'h0003;
        for (int i = 1; i <= 10; i++) begin
            apply_stimulus(16'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i),
                           (i <= 9), (i <= 9), CORE_OFS + 16'(i));
        end
        @(negedge clk);
        check_output("t3_level_full", 16'(fifo_level), 16'd8);
        check_output("t3_overflow", 16'(overflow), 16'h1);
        check_output("t3_in_valid", 16'(in_valid), 16'h1);
        check_output("t3_head_x", x_in, 16'h0001);
        tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        @(negedge clk);
        check_output("t3_overflow_cleared", 16'(overflow), 16'h0);

        // Simultaneous push/pop at full, in the IDLE-pop cycle after the first result
        $display("[TB] push and pop at full");
        tick();
        controller_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (y_valid === 1'b1) found = 1'b1;
        end
        check_output("t4_first_result", 16'(found), 16'h1);
        apply_stimulus(16'h000B, 16'h010B, 16'h020B, 1'b1, 1'b1, 16'h113F);
        @(negedge clk);
        check_output("t4_level", 16'(fifo_level), 16'd8);
        check_output("t4_no_overflow", 16'(overflow), 16'h0);
        wait_drain(300, "t4_drain");

        // Timeout: core accepts but never answers
        $display("[TB] timeout");
        core_respond = 1'b0;
        mu_cfg = 16'h0007;
        apply_stimulus(16'h0EEE, 16'h0E0E, 16'h00EE, 1'b1, 1'b1, 16'h0000);
        apply_stimulus(16'h0FFF, 16'h0F0F, 16'h00FF, 1'b1, 1'b1, 16'h0000);
        wait_in_valid(10, "t5_issue");
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (y_valid === 1'b1) found = 1'b1;
        end
        check_output("t5_timeout_latency", 16'(lat), 16'd17);
        check_output("t5_timeout_flag", 16'(timeout), 16'h1);
        @(negedge clk);
        check_output("t5_next_issue", 16'(in_valid), 16'h1);
        check_output("t5_next_x", x_in, 16'h0FFF);
        wait_drain(60, "t5_drain");
        tick();
        inject_req++;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (y_valid !== 1'b0 || in_valid !== 1'b0) bad++;
        end
        check_output("t5_late_ignored", 16'(bad), 16'h0);
        check_output("t5_timeout_sticky", 16'(timeout), 16'h1);

        // Reset mid-WAIT_OUT with 3 tuples queued
        $display("[TB] reset mid-transaction");
        tick();
        apply_stimulus(16'h0111, 16'h0222, 16'h0333, 1'b1, 1'b0, 16'h0000);
        apply_stimulus(16'h0444, 16'h0555, 16'h0666, 1'b0, 1'b0, 16'h0000);
        apply_stimulus(16'h0777, 16'h0888, 16'h0999, 1'b0, 1'b0, 16'h0000);
        apply_stimulus(16'h0AAA, 16'h0BBB, 16'h0CCC, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        check_output("t6_level_before", 16'(fifo_level), 16'd3);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_output("t6_in_valid", 16'(in_valid), 16'h0);
        check_output("t6_y_valid", 16'(y_valid), 16'h0);
        check_output("t6_overflow", 16'(overflow), 16'h0);
        check_output("t6_timeout", 16'(timeout), 16'h0);
        check_output("t6_x_in", x_in, 16'h0);
        check_output("t6_e_in", e_in, 16'h0);
        check_output("t6_a_in", a_in, 16'h0);
        check_output("t6_u_in", u_in, 16'h0);
        check_output("t6_y_data", y_data, 16'h0);
        check_output("t6_level", 16'(fifo_level), 16'h0);
        tick();
        inject_req++;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (y_valid !== 1'b0 || in_valid !== 1'b0) bad++;
        end
        check_output("t6_late_ignored", 16'(bad), 16'h0);
        check_output("t6_tx_queue_empty", 16'(exp_tx.size()), 16'h0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
